// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request, response and ALU-side signals of the shared-ALU arbiter.
// Latency: none; pure wiring bundle.
// Backpressure: carries per-port valid/ready; the arbiter side drives ready.
interface alu_arbiter_if #(
   parameter int WIDTH = 8,
   parameter int OPW   = 4
);
   logic             req0_valid;
   logic             req0_ready;
   logic [OPW-1:0]   req0_op;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;

   logic             req1_valid;
   logic             req1_ready;
   logic [OPW-1:0]   req1_op;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;

   logic             rsp0_valid;
   logic             rsp1_valid;
   logic [WIDTH-1:0] rsp_result;
   logic             rsp_carry;
   logic             rsp_zero;

   logic [OPW-1:0]   alu_op;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [WIDTH-1:0] alu_result;
   logic             alu_carry;

   logic             busy;
   logic             last_grant;

   // Arbiter side.
   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b,
      input  req1_valid, req1_op, req1_a, req1_b,
      input  alu_result, alu_carry,
      output req0_ready, req1_ready,
      output rsp0_valid, rsp1_valid, rsp_result, rsp_carry, rsp_zero,
      output alu_op, alu_a, alu_b,
      output busy, last_grant
   );

   // Requester / ALU side.
   modport master (
      output req0_valid, req0_op, req0_a, req0_b,
      output req1_valid, req1_op, req1_a, req1_b,
      output alu_result, alu_carry,
      input  req0_ready, req1_ready,
      input  rsp0_valid, rsp1_valid, rsp_result, rsp_carry, rsp_zero,
      input  alu_op, alu_a, alu_b,
      input  busy, last_grant
   );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between the CPU core (port 0) and the host debug port (port 1).
// Latency: response strobe ALU_LAT+1 cycles after accept; next accept ALU_LAT+2 cycles after accept.
// Backpressure: ready only while IDLE; requests seen while busy are not queued.
// Build option: define ALU_ARB_FIXED_PRIO_EN so port 0 wins every tie (default is round-robin).
module alu_arbiter #(
   parameter int WIDTH   = 8,
   parameter int OPW     = 4,
   parameter int ALU_LAT = 1
) (
   input  logic         clk,
   input  logic         rst,
   alu_arbiter_if.slave bus
);
   // Counter is 4 bits wide, enough for the supported latency range 1..15.
   localparam logic [3:0] LAT_LOAD = 4'(ALU_LAT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [3:0]       cnt;
   logic [3:0]       cnt_nxt;
   logic             win0;
   logic             win1;
   logic             accept;
   logic             capture;
   logic             ready0;
   logic             ready1;

   logic [OPW-1:0]   alu_op_q;
   logic [WIDTH-1:0] alu_a_q;
   logic [WIDTH-1:0] alu_b_q;
   logic [WIDTH-1:0] result_q;
   logic             carry_q;
   logic             zero_q;
   logic             last_grant_q;

   // Select the port that would be granted if the arbiter were idle this cycle.
   always_comb begin
      win0 = 1'b0;
      win1 = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
      win1 = bus.req1_valid & ~bus.req0_valid;
`else
      // On a tie, the port that did not win last time goes next.
      win1 = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);
`endif
      win0 = bus.req0_valid & ~win1;
   end

   // Next-state, counter and handshake decode for the IDLE/WAIT/RESP sequence.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      capture   = 1'b0;
      ready0    = 1'b0;
      ready1    = 1'b0;
      case (state)
         IDLE: begin
            ready0 = win0;
            ready1 = win1;
            if (win0 | win1) begin
               accept    = 1'b1;
               cnt_nxt   = LAT_LOAD;
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (cnt == 4'd1) begin
               capture   = 1'b1;
               cnt_nxt   = 4'd0;
               state_nxt = RESP;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         RESP: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
         end
      endcase
   end

   // State and latency counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Operand latch on accept and result/flag capture at the end of the ALU window.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_op_q     <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         last_grant_q <= 1'b1;
         result_q     <= '0;
         carry_q      <= 1'b0;
         zero_q       <= 1'b0;
      end else begin
         if (accept) begin
            alu_op_q     <= win1 ? bus.req1_op : bus.req0_op;
            alu_a_q      <= win1 ? bus.req1_a  : bus.req0_a;
            alu_b_q      <= win1 ? bus.req1_b  : bus.req0_b;
            last_grant_q <= win1;
         end
         if (capture) begin
            result_q <= bus.alu_result;
            carry_q  <= bus.alu_carry;
            zero_q   <= ~|bus.alu_result;
         end
      end
   end

   // Ready is masked by reset so it drops immediately while reset is held.
   assign bus.req0_ready = ready0 & ~rst;
   assign bus.req1_ready = ready1 & ~rst;
   assign bus.rsp0_valid = (state == RESP) & ~last_grant_q;
   assign bus.rsp1_valid = (state == RESP) &  last_grant_q;
   assign bus.rsp_result = result_q;
   assign bus.rsp_carry  = carry_q;
   assign bus.rsp_zero   = zero_q;
   assign bus.alu_op     = alu_op_q;
   assign bus.alu_a      = alu_a_q;
   assign bus.alu_b      = alu_b_q;
   assign bus.busy       = (state != IDLE);
   assign bus.last_grant = last_grant_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed plus randomized checks of alu_arbiter against a transaction-level model.
// Two instances: ALU_LAT=1 for arbitration/datapath, ALU_LAT=4 for reset during an operation.
// Expectations follow ALU_ARB_FIXED_PRIO_EN when it is defined for the build.
module tb_alu_arbiter;
`ifdef ALU_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif
   localparam int L1 = 1;

   logic clk;
   logic rst1;
   logic rst4;

   alu_arbiter_if #(.WIDTH(8), .OPW(4)) b1 ();
   alu_arbiter_if #(.WIDTH(8), .OPW(4)) b4 ();

   alu_arbiter #(.WIDTH(8), .OPW(4), .ALU_LAT(1)) u_dut1 (.clk(clk), .rst(rst1), .bus(b1));
   alu_arbiter #(.WIDTH(8), .OPW(4), .ALU_LAT(4)) u_dut4 (.clk(clk), .rst(rst4), .bus(b4));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in ALU: {carry, result}. SUB reports borrow in the carry bit.
   function automatic logic [8:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         4'd0:    return {1'b0, a} + {1'b0, b};
         4'd1:    return {1'b0, a} - {1'b0, b};
         4'd2:    return {1'b0, a & b};
         4'd3:    return {1'b0, a ^ b};
         default: return {1'b0, a | b};
      endcase
   endfunction

   assign {b1.alu_carry, b1.alu_result} = alu_f(b1.alu_op, b1.alu_a, b1.alu_b);
   assign {b4.alu_carry, b4.alu_result} = alu_f(b4.alu_op, b4.alu_a, b4.alu_b);

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Transaction-level model of the ALU_LAT=1 instance.
   typedef struct {
      int         port;
      logic [7:0] res;
      logic       c;
      logic       z;
      int         due;
   } exp_t;

   exp_t       exp_q[$];
   int         cyc = 0;
   int         free_at = 0;
   bit         m_last = 1'b1;
   logic [7:0] held_res = '0;
   logic       held_c = 1'b0;
   logic       held_z = 1'b0;
   logic [3:0] m_op = '0;
   logic [7:0] m_a = '0;
   logic [7:0] m_b = '0;

   // Requester state per port.
   bit         v[2];
   int         left[2];
   logic [3:0] op_r[2];
   logic [7:0] a_r[2];
   logic [7:0] b_r[2];

   // Logs of what the DUT actually did.
   int         g_port[$];
   int         g_cyc[$];
   int         r_port[$];
   int         r_cyc[$];
   logic [7:0] r_res[$];
   logic       r_c[$];
   logic       r_z[$];

   task automatic rand_payload(input int p);
      op_r[p] = 4'($urandom_range(0, 4));
      a_r[p]  = 8'($urandom);
      b_r[p]  = 8'($urandom);
   endtask

   task automatic set_req(input int p, input int n);
      left[p] = n;
      v[p]    = 1'b1;
      rand_payload(p);
   endtask

   task automatic next_payload(input int p);
      left[p]--;
      if (left[p] > 0) rand_payload(p);
      else v[p] = 1'b0;
   endtask

   task automatic drive1();
      b1.req0_valid = v[0];
      b1.req0_op    = op_r[0];
      b1.req0_a     = a_r[0];
      b1.req0_b     = b_r[0];
      b1.req1_valid = v[1];
      b1.req1_op    = op_r[1];
      b1.req1_a     = a_r[1];
      b1.req1_b     = b_r[1];
   endtask

   // One cycle of the ALU_LAT=1 instance, entered just after a falling edge.
   task automatic tick1();
      int         w;
      bit         idle;
      bit         rv0;
      bit         rv1;
      logic [8:0] r;
      exp_t       e;
      drive1();
      #1;
      idle = (cyc >= free_at);
      w = -1;
      if (idle) begin
         if (v[0] && v[1]) w = (FIXED || m_last) ? 0 : 1;
         else if (v[0]) w = 0;
         else if (v[1]) w = 1;
      end
      rv0 = 1'b0;
      rv1 = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         e = exp_q.pop_front();
         held_res = e.res;
         held_c   = e.c;
         held_z   = e.z;
         rv0 = (e.port == 0);
         rv1 = (e.port == 1);
      end
      chk("ready0", b1.req0_ready, w == 0);
      chk("ready1", b1.req1_ready, w == 1);
      chk("busy", b1.busy, !idle);
      chk("rsp0_valid", b1.rsp0_valid, rv0);
      chk("rsp1_valid", b1.rsp1_valid, rv1);
      chk("rsp_result", b1.rsp_result, held_res);
      chk("rsp_carry", b1.rsp_carry, held_c);
      chk("rsp_zero", b1.rsp_zero, held_z);
      chk("last_grant", b1.last_grant, m_last);
      chk("alu_op", b1.alu_op, m_op);
      chk("alu_a", b1.alu_a, m_a);
      chk("alu_b", b1.alu_b, m_b);
      if (b1.req0_valid && b1.req0_ready) begin g_port.push_back(0); g_cyc.push_back(cyc); end
      if (b1.req1_valid && b1.req1_ready) begin g_port.push_back(1); g_cyc.push_back(cyc); end
      if (b1.rsp0_valid || b1.rsp1_valid) begin
         r_port.push_back(b1.rsp1_valid ? 1 : 0);
         r_cyc.push_back(cyc);
         r_res.push_back(b1.rsp_result);
         r_c.push_back(b1.rsp_carry);
         r_z.push_back(b1.rsp_zero);
      end
      if (w >= 0) begin
         r = alu_f(op_r[w], a_r[w], b_r[w]);
         exp_q.push_back('{w, r[7:0], r[8], (r[7:0] == 8'd0), cyc + L1 + 1});
         free_at = cyc + L1 + 2;
         m_last  = (w == 1);
         m_op    = op_r[w];
         m_a     = a_r[w];
         m_b     = b_r[w];
         next_payload(w);
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic drain1(input string tag, input int budget);
      int n;
      n = 0;
      while ((v[0] || v[1] || exp_q.size() > 0 || cyc < free_at) && n < budget) begin
         tick1();
         n++;
      end
      chk(tag, n < budget, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int         gb;
      int         rb;
      int         n;
      bit         seen;

      rst1 = 1'b1;
      rst4 = 1'b1;
      v[0] = 1'b0; v[1] = 1'b0;
      left[0] = 0; left[1] = 0;
      for (int p = 0; p < 2; p++) begin
         op_r[p] = '0; a_r[p] = '0; b_r[p] = '0;
      end
      b4.req0_valid = 1'b0; b4.req0_op = '0; b4.req0_a = '0; b4.req0_b = '0;
      b4.req1_valid = 1'b0; b4.req1_op = '0; b4.req1_a = '0; b4.req1_b = '0;

      // Both ports valid while reset is held: nothing may be granted yet.
      set_req(0, 1);
      set_req(1, 1);
      drive1();
      repeat (2) @(negedge clk);
      #1;
      chk("rst_ready0", b1.req0_ready, 1'b0);
      chk("rst_ready1", b1.req1_ready, 1'b0);
      chk("rst_rsp0", b1.rsp0_valid, 1'b0);
      chk("rst_rsp1", b1.rsp1_valid, 1'b0);
      chk("rst_busy", b1.busy, 1'b0);
      chk("rst_result", b1.rsp_result, 8'h00);
      chk("rst_carry", b1.rsp_carry, 1'b0);
      chk("rst_zero", b1.rsp_zero, 1'b0);
      chk("rst_alu_op", b1.alu_op, 4'h0);
      chk("rst_alu_a", b1.alu_a, 8'h00);
      chk("rst_alu_b", b1.alu_b, 8'h00);
      chk("rst_last_grant", b1.last_grant, 1'b1);
      @(negedge clk);
      rst1 = 1'b0;

      // Simultaneous first requests.
      drain1("t2_timeout", 50);
      chk("t2_g0_port", g_port[0], 0);
      chk("t2_g0_cyc", g_cyc[0], 0);
      chk("t2_g1_port", g_port[1], 1);
      chk("t2_g1_cyc", g_cyc[1], 3);
      chk("t2_r0_cyc", r_cyc[0], 2);
      chk("t2_r1_port", r_port[1], 1);
      chk("t2_r1_cyc", r_cyc[1], 5);

      // Sustained contention for 8 operations.
      gb = g_port.size();
      set_req(0, 8);
      set_req(1, 8);
      n = 0;
      while (g_port.size() < gb + 8 && n < 100) begin
         tick1();
         n++;
      end
      chk("t3_accepts", g_port.size() >= gb + 8, 1'b1);
      for (int i = 0; i < 8; i++) begin
         chk("t3_grant", g_port[gb + i], FIXED ? 0 : (i % 2));
         if (i > 0) chk("t3_spacing", g_cyc[gb + i] - g_cyc[gb + i - 1], L1 + 2);
      end
      drain1("t3_timeout", 200);

      // Single request, ADD 5 + 3.
      gb = g_port.size();
      rb = r_port.size();
      set_req(0, 1);
      op_r[0] = 4'd0; a_r[0] = 8'h05; b_r[0] = 8'h03;
      drain1("t1_timeout", 20);
      chk("t1_nrsp", r_port.size() - rb, 1);
      chk("t1_grant", g_port[gb], 0);
      chk("t1_rsp_port", r_port[rb], 0);
      chk("t1_latency", r_cyc[rb] - g_cyc[gb], 2);
      chk("t1_result", r_res[rb], 8'h08);
      chk("t1_carry", r_c[rb], 1'b0);
      chk("t1_zero", r_z[rb], 1'b0);

      // Carry and zero, ADD 0xFF + 0x01.
      rb = r_port.size();
      set_req(1, 1);
      op_r[1] = 4'd0; a_r[1] = 8'hFF; b_r[1] = 8'h01;
      drain1("t4_timeout", 20);
      chk("t4_rsp_port", r_port[rb], 1);
      chk("t4_result", r_res[rb], 8'h00);
      chk("t4_carry", r_c[rb], 1'b1);
      chk("t4_zero", r_z[rb], 1'b1);

      // Randomized traffic.
      for (int i = 0; i < 80; i++) begin
         for (int p = 0; p < 2; p++)
            if (!v[p] && $urandom_range(0, 3) == 0) set_req(p, $urandom_range(1, 3));
         tick1();
      end
      drain1("rand_timeout", 200);

      // ALU_LAT=4 instance: complete one op, then reset during the second WAIT of the next.
      rst4 = 1'b0;
      repeat (2) @(negedge clk);
      b4.req0_valid = 1'b1; b4.req0_op = 4'd0; b4.req0_a = 8'h40; b4.req0_b = 8'h41;
      #1;
      chk("l4_ready0", b4.req0_ready, 1'b1);
      @(negedge clk);
      b4.req0_valid = 1'b0;
      n = 1;
      #1;
      while (!b4.rsp0_valid && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("l4_first_lat", n, 5);
      chk("l4_first_res", b4.rsp_result, 8'h81);
      @(negedge clk);
      b4.req0_valid = 1'b1; b4.req0_op = 4'd3; b4.req0_a = 8'h5A; b4.req0_b = 8'hC3;
      #1;
      chk("l4_ready0_b", b4.req0_ready, 1'b1);
      @(negedge clk);
      b4.req0_valid = 1'b0;
      @(negedge clk);
      #1;
      chk("l4_busy_pre", b4.busy, 1'b1);
      rst4 = 1'b1;
      #1;
      chk("l4_rst_busy", b4.busy, 1'b0);
      chk("l4_rst_alu_op", b4.alu_op, 4'h0);
      chk("l4_rst_alu_a", b4.alu_a, 8'h00);
      chk("l4_rst_alu_b", b4.alu_b, 8'h00);
      chk("l4_rst_last", b4.last_grant, 1'b1);
      chk("l4_rst_result", b4.rsp_result, 8'h00);
      chk("l4_rst_carry", b4.rsp_carry, 1'b0);
      chk("l4_rst_zero", b4.rsp_zero, 1'b0);
      chk("l4_rst_rsp0", b4.rsp0_valid, 1'b0);
      chk("l4_rst_rsp1", b4.rsp1_valid, 1'b0);
      repeat (2) @(negedge clk);
      rst4 = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         #1;
         seen = seen | b4.rsp0_valid | b4.rsp1_valid;
         @(negedge clk);
      end
      chk("l4_no_rsp", seen, 1'b0);
      b4.req1_valid = 1'b1; b4.req1_op = 4'd0; b4.req1_a = 8'h10; b4.req1_b = 8'h20;
      #1;
      chk("l4_ready1", b4.req1_ready, 1'b1);
      chk("l4_ready0_off", b4.req0_ready, 1'b0);
      @(negedge clk);
      b4.req1_valid = 1'b0;
      n = 1;
      seen = 1'b0;
      #1;
      while (!b4.rsp1_valid && n < 20) begin
         seen = seen | b4.rsp0_valid;
         @(negedge clk);
         #1;
         n++;
      end
      chk("l4_p1_lat", n, 5);
      chk("l4_p1_res", b4.rsp_result, 8'h30);
      chk("l4_p1_carry", b4.rsp_carry, 1'b0);
      chk("l4_p1_zero", b4.rsp_zero, 1'b0);
      chk("l4_p1_last", b4.last_grant, 1'b1);
      chk("l4_p1_no_rsp0", seen, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
